// File: rtl/program_memory_loader_if.sv
// Byte-stream handshake and instruction-RAM write bus for program_memory_loader.
// The loader uses the slave modport; the byte source / RAM side uses master.
interface program_memory_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;

  modport slave (
    input  ByteIn, ByteValid,
    output ByteReady, MemWrite, WriteAddress, WriteData
  );

  modport master (
    output ByteIn, ByteValid,
    input  ByteReady, MemWrite, WriteAddress, WriteData
  );
endinterface

// File: rtl/program_memory_loader.sv
// Boot loader: length byte N, then 4*N little-endian bytes written as words to instruction RAM.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte before Done.
module program_memory_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Start,
  program_memory_loader_if.slave       bus,
  output logic                         CpuHold,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Error
);

  localparam int NW = $clog2(MEMORY_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, DONE, ERROR} state_t;

  state_t        state;
  logic [NW-1:0] n;
  logic [NW-1:0] idx;
  logic [1:0]    bcnt;
  logic [23:0]   word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      n                <= '0;
      idx              <= '0;
      bcnt             <= '0;
      word             <= '0;
      bus.ByteReady    <= 1'b0;
      bus.MemWrite     <= 1'b0;
      bus.WriteAddress <= '0;
      bus.WriteData    <= '0;
      CpuHold          <= 1'b0;
      Busy             <= 1'b0;
      Done             <= 1'b0;
      Error            <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum              <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (Start) begin
            state         <= LEN;
            bus.ByteReady <= 1'b1;
            Done          <= 1'b0;
            Error         <= 1'b0;
            CpuHold       <= 1'b1;
            Busy          <= 1'b1;
          end
        end

        LEN: begin
          if (bus.ByteValid) begin
            if (bus.ByteIn == 8'd0 || int'(bus.ByteIn) > MEMORY_DEPTH) begin
              state         <= ERROR;
              bus.ByteReady <= 1'b0;
              Busy          <= 1'b0;
              Error         <= 1'b1;
            end else begin
              state <= DATA;
              n     <= NW'(bus.ByteIn);
              idx   <= '0;
              bcnt  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              sum   <= '0;
`endif
            end
          end
        end

        DATA: begin
          if (bus.ByteValid) begin
            bcnt <= bcnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum  <= sum + bus.ByteIn;
`endif
            // Lane 3 bypasses the assembly register straight into WriteData.
            case (bcnt)
              2'd0: word[7:0]   <= bus.ByteIn;
              2'd1: word[15:8]  <= bus.ByteIn;
              2'd2: word[23:16] <= bus.ByteIn;
              default: begin
                state            <= WRITE;
                bus.ByteReady    <= 1'b0;
                bus.MemWrite     <= 1'b1;
                bus.WriteAddress <= DATA_WIDTH'({idx, 2'b00});
                bus.WriteData    <= DATA_WIDTH'({bus.ByteIn, word});
              end
            endcase
          end
        end

        WRITE: begin
          bus.MemWrite <= 1'b0;
          idx          <= idx + NW'(1);
          if (idx == n - NW'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state         <= CHK;
            bus.ByteReady <= 1'b1;
`else
            state         <= DONE;
            Busy          <= 1'b0;
            Done          <= 1'b1;
            CpuHold       <= 1'b0;
`endif
          end else begin
            state         <= DATA;
            bus.ByteReady <= 1'b1;
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK: begin
          if (bus.ByteValid) begin
            bus.ByteReady <= 1'b0;
            Busy          <= 1'b0;
            if (bus.ByteIn == sum) begin
              state   <= DONE;
              Done    <= 1'b1;
              CpuHold <= 1'b0;
            end else begin
              state   <= ERROR;
              Error   <= 1'b1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
